// File: rtl/riesgos_pkg.sv
// Shared constants for the hazard/forwarding unit: operand-mux selects, MDU FSM encoding.
// Pure declarations; no logic, no latency, no flow control.
package riesgos_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/unidad_cortocircuito_sel.sv
// Priority forwarding selector for one source operand: MEM beats WB, $zero never forwards.
// Purely combinational; no flow control.
module unidad_cortocircuito_sel
    import riesgos_pkg::*;
#(
    parameter int NB_REG = 5
) (
    input  logic [NB_REG-1:0] src,
    input  logic [NB_REG-1:0] rd_mem,
    input  logic              wr_mem,
    input  logic [NB_REG-1:0] rd_wb,
    input  logic              wr_wb,
    input  logic              en_wb,
    output logic [1:0]        sel
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = wr_mem && (rd_mem != NB_REG'(REG_ZERO)) && (rd_mem == src);
    assign hit_wb  = en_wb && wr_wb && (rd_wb != NB_REG'(REG_ZERO)) && (rd_wb == src);

    always_comb begin
        sel = FWD_NONE;
        if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/unidad_riesgos.sv
// Hazard/forwarding unit for the 5-stage pipeline: EX/ID operand selects, load/branch stalls, MDU occupancy.
// Selects and stalls are combinational; MDU FSM and stall counter are registered. Stalls are its backpressure output.
module unidad_riesgos
    import riesgos_pkg::*;
#(
    parameter int NB_REG         = 5,
    parameter int MDU_LAT        = 4,
    parameter int NB_LAT         = 4,
    parameter int NB_CNT         = 16,
    parameter int RF_WRITE_FIRST = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NB_REG-1:0] i_rs_ID,
    input  logic [NB_REG-1:0] i_rt_ID,
    input  logic              i_uses_rt_ID,
    input  logic              i_branch_ID,
    input  logic [NB_REG-1:0] i_rs_EX,
    input  logic [NB_REG-1:0] i_rt_EX,
    input  logic [NB_REG-1:0] i_rd_EX,
    input  logic              i_write_reg_EX,
    input  logic              i_mem_read_EX,
    input  logic              i_mdu_start_EX,
    input  logic [NB_REG-1:0] i_rd_MEM,
    input  logic              i_write_reg_MEM,
    input  logic              i_mem_read_MEM,
    input  logic [NB_REG-1:0] i_rd_WB,
    input  logic              i_write_reg_WB,
    input  logic              i_clr_cnt,
    output logic [1:0]        o_corto_rs,
    output logic [1:0]        o_corto_rt,
    output logic [1:0]        o_corto_br_rs,
    output logic [1:0]        o_corto_br_rt,
    output logic              o_stall_pc,
    output logic              o_stall_ifid,
    output logic              o_flush_idex,
    output logic              o_stall_idex,
    output logic              o_flush_exmem,
    output logic              o_mdu_busy,
    output logic [NB_CNT-1:0] o_stall_cycles
);

    localparam int                CNT_LOAD_I = (MDU_LAT >= 3) ? (MDU_LAT - 3) : 0;
    localparam logic [NB_LAT-1:0] CNT_LOAD   = NB_LAT'(CNT_LOAD_I);

    function automatic logic reg_match(input logic [NB_REG-1:0] a, input logic [NB_REG-1:0] r);
        return (r != NB_REG'(REG_ZERO)) && (r == a);
    endfunction

    // ---------------- operand forwarding ----------------
    logic [1:0] sel_rs_ex;
    logic [1:0] sel_rt_ex;
    logic [1:0] sel_rs_id;
    logic [1:0] sel_rt_id;
    logic       wr_mem_id;
    logic       en_wb_id;

    // Branch compare sits in ID: a load in MEM has no data yet, so only ALU results forward.
    assign wr_mem_id = i_branch_ID && i_write_reg_MEM && !i_mem_read_MEM;
    assign en_wb_id  = (RF_WRITE_FIRST == 0);

    unidad_cortocircuito_sel #(.NB_REG(NB_REG)) u_sel_rs_ex (
        .src    (i_rs_EX),
        .rd_mem (i_rd_MEM),
        .wr_mem (i_write_reg_MEM),
        .rd_wb  (i_rd_WB),
        .wr_wb  (i_write_reg_WB),
        .en_wb  (1'b1),
        .sel    (sel_rs_ex)
    );

    unidad_cortocircuito_sel #(.NB_REG(NB_REG)) u_sel_rt_ex (
        .src    (i_rt_EX),
        .rd_mem (i_rd_MEM),
        .wr_mem (i_write_reg_MEM),
        .rd_wb  (i_rd_WB),
        .wr_wb  (i_write_reg_WB),
        .en_wb  (1'b1),
        .sel    (sel_rt_ex)
    );

    unidad_cortocircuito_sel #(.NB_REG(NB_REG)) u_sel_rs_id (
        .src    (i_rs_ID),
        .rd_mem (i_rd_MEM),
        .wr_mem (wr_mem_id),
        .rd_wb  (i_rd_WB),
        .wr_wb  (i_write_reg_WB),
        .en_wb  (en_wb_id),
        .sel    (sel_rs_id)
    );

    unidad_cortocircuito_sel #(.NB_REG(NB_REG)) u_sel_rt_id (
        .src    (i_rt_ID),
        .rd_mem (i_rd_MEM),
        .wr_mem (wr_mem_id),
        .rd_wb  (i_rd_WB),
        .wr_wb  (i_write_reg_WB),
        .en_wb  (en_wb_id),
        .sel    (sel_rt_id)
    );

    // ---------------- data hazards ----------------
    logic src_ex;
    logic src_mem;
    logic h_load_use;
    logic h_branch_ex;
    logic h_branch_mem;
    logic hazard;

    assign src_ex  = reg_match(i_rs_ID, i_rd_EX)  || (i_uses_rt_ID && reg_match(i_rt_ID, i_rd_EX));
    assign src_mem = reg_match(i_rs_ID, i_rd_MEM) || (i_uses_rt_ID && reg_match(i_rt_ID, i_rd_MEM));

    assign h_load_use   = i_mem_read_EX && i_write_reg_EX && src_ex;
    assign h_branch_ex  = i_branch_ID && i_write_reg_EX && src_ex;
    assign h_branch_mem = i_branch_ID && i_mem_read_MEM && i_write_reg_MEM && src_mem;
    assign hazard       = h_load_use || h_branch_ex || h_branch_mem;

    // ---------------- MDU occupancy FSM ----------------
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [NB_LAT-1:0] cnt;
    logic [NB_LAT-1:0] cnt_nxt;
    logic              mdu_stall;

    // DONE ignores mdu_start: it is still the same instruction, now leaving EX.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mdu_stall = 1'b0;
        case (state)
            ST_RUN: begin
                if (i_mdu_start_EX && (MDU_LAT > 1)) begin
                    mdu_stall = 1'b1;
                    if (MDU_LAT == 2) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                mdu_stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - NB_LAT'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------- pipeline controls ----------------
    logic hazard_live;
    logic stall_front;

    // ID is frozen by the MDU stall, so its hazards are meaningless until it releases.
    assign hazard_live = hazard && !mdu_stall;
    assign stall_front = i_rst_n && (mdu_stall || hazard_live);

    assign o_corto_rs    = i_rst_n ? sel_rs_ex : FWD_NONE;
    assign o_corto_rt    = i_rst_n ? sel_rt_ex : FWD_NONE;
    assign o_corto_br_rs = i_rst_n ? sel_rs_id : FWD_NONE;
    assign o_corto_br_rt = i_rst_n ? sel_rt_id : FWD_NONE;

    assign o_stall_pc    = stall_front;
    assign o_stall_ifid  = stall_front;
    assign o_flush_idex  = i_rst_n && hazard_live;
    assign o_stall_idex  = i_rst_n && mdu_stall;
    assign o_flush_exmem = i_rst_n && mdu_stall;
    assign o_mdu_busy    = i_rst_n && mdu_stall;

    // ---------------- stall performance counter ----------------
    logic [NB_CNT-1:0] stall_cycles;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cycles <= '0;
        end else if (i_clr_cnt) begin
            stall_cycles <= '0;
        end else if (stall_front && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + NB_CNT'(1);
        end
    end

    assign o_stall_cycles = stall_cycles;

endmodule

// File: tb/tb_unidad_riesgos.sv
// Bench for unidad_riesgos: default instance plus an MDU_LAT=1 / NB_CNT=2 / RF_WRITE_FIRST=0 instance.
// Vector table for the combinational paths, hand sequences for the multi-cycle cases.
module tb_unidad_riesgos;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [4:0] i_rs_ID, i_rt_ID, i_rs_EX, i_rt_EX, i_rd_EX, i_rd_MEM, i_rd_WB;
    logic       i_uses_rt_ID, i_branch_ID, i_write_reg_EX, i_mem_read_EX, i_mdu_start_EX;
    logic       i_write_reg_MEM, i_mem_read_MEM, i_write_reg_WB, i_clr_cnt;

    logic [1:0]  m_rs, m_rt, m_brs, m_brt;
    logic        m_pc, m_ifid, m_fidex, m_sidex, m_fexmem, m_busy;
    logic [15:0] m_cnt;
    logic [1:0]  a_rs, a_rt, a_brs, a_brt;
    logic        a_pc, a_ifid, a_fidex, a_sidex, a_fexmem, a_busy;
    logic [1:0]  a_cnt;

    logic [5:0] m_bits, a_bits;
    assign m_bits = {m_busy, m_pc, m_ifid, m_fidex, m_sidex, m_fexmem};
    assign a_bits = {a_busy, a_pc, a_ifid, a_fidex, a_sidex, a_fexmem};

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    unidad_riesgos u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rs_ID(i_rs_ID), .i_rt_ID(i_rt_ID), .i_uses_rt_ID(i_uses_rt_ID), .i_branch_ID(i_branch_ID),
        .i_rs_EX(i_rs_EX), .i_rt_EX(i_rt_EX), .i_rd_EX(i_rd_EX),
        .i_write_reg_EX(i_write_reg_EX), .i_mem_read_EX(i_mem_read_EX), .i_mdu_start_EX(i_mdu_start_EX),
        .i_rd_MEM(i_rd_MEM), .i_write_reg_MEM(i_write_reg_MEM), .i_mem_read_MEM(i_mem_read_MEM),
        .i_rd_WB(i_rd_WB), .i_write_reg_WB(i_write_reg_WB), .i_clr_cnt(i_clr_cnt),
        .o_corto_rs(m_rs), .o_corto_rt(m_rt), .o_corto_br_rs(m_brs), .o_corto_br_rt(m_brt),
        .o_stall_pc(m_pc), .o_stall_ifid(m_ifid), .o_flush_idex(m_fidex), .o_stall_idex(m_sidex),
        .o_flush_exmem(m_fexmem), .o_mdu_busy(m_busy), .o_stall_cycles(m_cnt)
    );

    unidad_riesgos #(.MDU_LAT(1), .NB_CNT(2), .RF_WRITE_FIRST(0)) u_alt (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rs_ID(i_rs_ID), .i_rt_ID(i_rt_ID), .i_uses_rt_ID(i_uses_rt_ID), .i_branch_ID(i_branch_ID),
        .i_rs_EX(i_rs_EX), .i_rt_EX(i_rt_EX), .i_rd_EX(i_rd_EX),
        .i_write_reg_EX(i_write_reg_EX), .i_mem_read_EX(i_mem_read_EX), .i_mdu_start_EX(i_mdu_start_EX),
        .i_rd_MEM(i_rd_MEM), .i_write_reg_MEM(i_write_reg_MEM), .i_mem_read_MEM(i_mem_read_MEM),
        .i_rd_WB(i_rd_WB), .i_write_reg_WB(i_write_reg_WB), .i_clr_cnt(i_clr_cnt),
        .o_corto_rs(a_rs), .o_corto_rt(a_rt), .o_corto_br_rs(a_brs), .o_corto_br_rt(a_brt),
        .o_stall_pc(a_pc), .o_stall_ifid(a_ifid), .o_flush_idex(a_fidex), .o_stall_idex(a_sidex),
        .o_flush_exmem(a_fexmem), .o_mdu_busy(a_busy), .o_stall_cycles(a_cnt)
    );

    typedef struct {
        logic [4:0] rs_id, rt_id;
        logic       uses_rt, branch;
        logic [4:0] rs_ex, rt_ex, rd_ex;
        logic       wr_ex, mr_ex;
        logic [4:0] rd_mem;
        logic       wr_mem, mr_mem;
        logic [4:0] rd_wb;
        logic       wr_wb;
        logic [1:0] e_rs, e_rt, e_brs, e_brt;
        logic       e_stall;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tv[NVEC];

    function automatic vec_t mk(input int rs_id, rt_id, uses_rt, branch,
                                input int rs_ex, rt_ex, rd_ex, wr_ex, mr_ex,
                                input int rd_mem, wr_mem, mr_mem, rd_wb, wr_wb,
                                input int e_rs, e_rt, e_brs, e_brt, e_stall);
        vec_t v;
        v.rs_id = 5'(rs_id);   v.rt_id = 5'(rt_id);
        v.uses_rt = 1'(uses_rt); v.branch = 1'(branch);
        v.rs_ex = 5'(rs_ex);   v.rt_ex = 5'(rt_ex);   v.rd_ex = 5'(rd_ex);
        v.wr_ex = 1'(wr_ex);   v.mr_ex = 1'(mr_ex);
        v.rd_mem = 5'(rd_mem); v.wr_mem = 1'(wr_mem); v.mr_mem = 1'(mr_mem);
        v.rd_wb = 5'(rd_wb);   v.wr_wb = 1'(wr_wb);
        v.e_rs = 2'(e_rs);     v.e_rt = 2'(e_rt);
        v.e_brs = 2'(e_brs);   v.e_brt = 2'(e_brt);
        v.e_stall = 1'(e_stall);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        i_rs_ID = '0; i_rt_ID = '0; i_uses_rt_ID = 1'b0; i_branch_ID = 1'b0;
        i_rs_EX = '0; i_rt_EX = '0; i_rd_EX = '0;
        i_write_reg_EX = 1'b0; i_mem_read_EX = 1'b0; i_mdu_start_EX = 1'b0;
        i_rd_MEM = '0; i_write_reg_MEM = 1'b0; i_mem_read_MEM = 1'b0;
        i_rd_WB = '0; i_write_reg_WB = 1'b0; i_clr_cnt = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        i_rs_ID = v.rs_id; i_rt_ID = v.rt_id; i_uses_rt_ID = v.uses_rt; i_branch_ID = v.branch;
        i_rs_EX = v.rs_ex; i_rt_EX = v.rt_ex; i_rd_EX = v.rd_ex;
        i_write_reg_EX = v.wr_ex; i_mem_read_EX = v.mr_ex;
        i_rd_MEM = v.rd_mem; i_write_reg_MEM = v.wr_mem; i_mem_read_MEM = v.mr_mem;
        i_rd_WB = v.rd_wb; i_write_reg_WB = v.wr_wb;
    endtask

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_use();
        idle();
        i_rd_EX = 5'd3; i_write_reg_EX = 1'b1; i_mem_read_EX = 1'b1; i_rs_ID = 5'd3;
    endtask

    initial begin
        //       rs_id rt_id ur br  rs_ex rt_ex rd_ex wx mx  rdm wm mm  rdw ww  ers ert ebrs ebrt stall
        tv[0]  = mk(0, 0, 1, 1,   0, 0, 0, 1, 1,   0, 1, 0,   0, 1,   0, 0, 0, 0, 0);
        tv[1]  = mk(1, 2, 1, 0,   5, 7, 0, 0, 0,   5, 1, 0,   5, 1,   2, 0, 0, 0, 0);
        tv[2]  = mk(1, 2, 1, 0,   5, 5, 0, 0, 0,   5, 0, 0,   5, 1,   1, 1, 0, 0, 0);
        tv[3]  = mk(1, 2, 1, 0,   7, 6, 0, 0, 0,   6, 1, 0,   7, 1,   1, 2, 0, 0, 0);
        tv[4]  = mk(1, 3, 1, 0,   0, 0, 3, 1, 1,   0, 0, 0,   0, 0,   0, 0, 0, 0, 1);
        tv[5]  = mk(1, 3, 0, 0,   0, 0, 3, 1, 1,   0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        tv[6]  = mk(3, 1, 0, 0,   0, 0, 3, 1, 1,   0, 0, 0,   0, 0,   0, 0, 0, 0, 1);
        tv[7]  = mk(3, 1, 1, 0,   0, 0, 3, 1, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        tv[8]  = mk(3, 1, 1, 0,   0, 0, 3, 0, 1,   0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        tv[9]  = mk(4, 0, 1, 1,   0, 0, 4, 1, 0,   4, 1, 0,   0, 0,   0, 0, 2, 0, 1);
        tv[10] = mk(8, 9, 1, 1,   0, 0, 0, 0, 0,   9, 1, 1,   0, 0,   0, 0, 0, 0, 1);
        tv[11] = mk(8, 9, 1, 1,   0, 0, 0, 0, 0,   9, 1, 0,   0, 0,   0, 0, 0, 2, 0);
        tv[12] = mk(9, 1, 1, 0,   0, 0, 0, 0, 0,   9, 1, 0,   0, 0,   0, 0, 0, 0, 0);
        tv[13] = mk(9, 1, 1, 0,   0, 0, 0, 0, 0,   9, 1, 1,   0, 0,   0, 0, 0, 0, 0);
        tv[14] = mk(8, 8, 1, 1,   0, 0, 0, 0, 0,   0, 0, 0,   8, 1,   0, 0, 0, 0, 0);
        tv[15] = mk(1, 4, 0, 1,   0, 0, 4, 1, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        tv[16] = mk(1, 4, 1, 1,   0, 0, 4, 1, 0,   0, 0, 0,   0, 0,   0, 0, 0, 0, 1);

        // Reset with live-looking inputs: everything must read as zero.
        idle();
        i_rst_n = 1'b0;
        load_use();
        i_mdu_start_EX = 1'b1;
        i_rs_EX = 5'd5; i_rd_MEM = 5'd5; i_write_reg_MEM = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_bits_main", 32'(m_bits), 32'h0);
        check("rst_bits_alt", 32'(a_bits), 32'h0);
        check("rst_corto_rs", 32'(m_rs), 32'h0);
        check("rst_cnt_main", 32'(m_cnt), 32'h0);
        check("rst_cnt_alt", 32'(a_cnt), 32'h0);

        next();
        i_rst_n = 1'b1;
        idle();

        for (int i = 0; i < NVEC; i++) begin
            next();
            drive(tv[i]);
            @(negedge i_clk);
            check($sformatf("v%0d_rs", i), 32'(m_rs), 32'(tv[i].e_rs));
            check($sformatf("v%0d_rt", i), 32'(m_rt), 32'(tv[i].e_rt));
            check($sformatf("v%0d_brs", i), 32'(m_brs), 32'(tv[i].e_brs));
            check($sformatf("v%0d_brt", i), 32'(m_brt), 32'(tv[i].e_brt));
            check($sformatf("v%0d_bits", i), 32'(m_bits), tv[i].e_stall ? 32'h1C : 32'h0);
            check($sformatf("v%0d_bits_alt", i), 32'(a_bits), tv[i].e_stall ? 32'h1C : 32'h0);
        end

        // WB-to-ID forwarding exists only without a write-first register file.
        next();
        drive(tv[14]);
        @(negedge i_clk);
        check("wb_id_alt_brs", 32'(a_brs), 32'h1);
        check("wb_id_alt_brt", 32'(a_brt), 32'h1);

        // Branch on a load: stall with load in EX, again with load in MEM, then free.
        next(); idle(); i_clr_cnt = 1'b1;
        next(); idle();
        i_branch_ID = 1'b1; i_rs_ID = 5'd4; i_uses_rt_ID = 1'b1;
        i_rd_EX = 5'd4; i_write_reg_EX = 1'b1; i_mem_read_EX = 1'b1;
        @(negedge i_clk);
        check("brld_c1_bits", 32'(m_bits), 32'h1C);
        next();
        i_rd_EX = '0; i_write_reg_EX = 1'b0; i_mem_read_EX = 1'b0;
        i_rd_MEM = 5'd4; i_write_reg_MEM = 1'b1; i_mem_read_MEM = 1'b1;
        @(negedge i_clk);
        check("brld_c2_bits", 32'(m_bits), 32'h1C);
        check("brld_c2_brs", 32'(m_brs), 32'h0);
        next();
        i_rd_MEM = '0; i_write_reg_MEM = 1'b0; i_mem_read_MEM = 1'b0;
        i_rd_WB = 5'd4; i_write_reg_WB = 1'b1;
        @(negedge i_clk);
        check("brld_c3_bits", 32'(m_bits), 32'h0);
        check("brld_c3_brs", 32'(m_brs), 32'h0);
        check("brld_c3_brs_alt", 32'(a_brs), 32'h1);
        check("brld_c3_cnt", 32'(m_cnt), 32'd2);
        next();
        i_rd_MEM = 5'd4; i_write_reg_MEM = 1'b1;
        @(negedge i_clk);
        check("br_prio_alt", 32'(a_brs), 32'h2);

        // MDU occupancy: 3 stall cycles with a masked branch hazard, then DONE.
        next(); idle(); i_clr_cnt = 1'b1;
        next(); idle();
        i_mdu_start_EX = 1'b1;
        i_branch_ID = 1'b1; i_rs_ID = 5'd4; i_rd_EX = 5'd4; i_write_reg_EX = 1'b1;
        i_rs_EX = 5'd5; i_rd_MEM = 5'd5; i_write_reg_MEM = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) next();
            @(negedge i_clk);
            check($sformatf("mdu_c%0d_bits", c), 32'(m_bits), 32'h3B);
            check($sformatf("mdu_c%0d_bits_alt", c), 32'(a_bits), 32'h1C);
        end
        check("mdu_fwd_live", 32'(m_rs), 32'h2);
        next();
        i_branch_ID = 1'b0; i_rd_EX = '0; i_write_reg_EX = 1'b0;
        @(negedge i_clk);
        check("mdu_done_bits", 32'(m_bits), 32'h0);
        next();
        i_mdu_start_EX = 1'b0;
        @(negedge i_clk);
        check("mdu_after_bits", 32'(m_bits), 32'h0);
        check("mdu_cnt", 32'(m_cnt), 32'd3);

        // Reset landing in BUSY aborts the MDU sequence.
        next(); idle(); i_mdu_start_EX = 1'b1;
        @(negedge i_clk);
        check("rbusy_c0_busy", 32'(m_busy), 32'h1);
        next();
        i_rst_n = 1'b0;
        i_rs_EX = 5'd5; i_rd_MEM = 5'd5; i_write_reg_MEM = 1'b1;
        @(negedge i_clk);
        check("rbusy_c1_bits", 32'(m_bits), 32'h0);
        check("rbusy_c1_rs", 32'(m_rs), 32'h0);
        next();
        i_rst_n = 1'b1; i_mdu_start_EX = 1'b0;
        @(negedge i_clk);
        check("rbusy_c2_bits", 32'(m_bits), 32'h0);
        check("rbusy_c2_cnt", 32'(m_cnt), 32'h0);
        check("rbusy_c2_rs", 32'(m_rs), 32'h2);

        // Counter saturation on the 2-bit instance, then clear winning over increment.
        for (int c = 0; c < 5; c++) begin
            next(); load_use();
        end
        next(); idle();
        @(negedge i_clk);
        check("sat_cnt_alt", 32'(a_cnt), 32'd3);
        check("sat_cnt_main", 32'(m_cnt), 32'd5);
        next(); load_use(); i_clr_cnt = 1'b1;
        next(); load_use();
        @(negedge i_clk);
        check("clr_cnt_alt", 32'(a_cnt), 32'd0);
        check("clr_cnt_main", 32'(m_cnt), 32'd0);
        next(); idle();
        @(negedge i_clk);
        check("clr_then_inc_alt", 32'(a_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unidad_riesgos.md
Name: unidad_riesgos

Overview:
Parametrised hazard and forwarding unit for the 5-stage MIPS pipeline. It succeeds the EX-only forwarding unit and adds:
- $zero exclusion on every forwarding and hazard comparison.
- ID-stage branch operand forwarding.
- Load-use and branch-dependency stall detection.
- A multi-cycle MDU occupancy FSM with counter.
- A saturating stall-cycle performance counter.
It sits beside the pipeline registers and drives their stall/flush controls and the EX/ID operand muxes.

Parameters:
NB_REG, 5, register-address width.
MDU_LAT, 4, cycles a multiply/divide occupies EX (1..2^NB_LAT-1; 1 means no stall).
NB_LAT, 4, MDU countdown-counter width.
NB_CNT, 16, stall performance-counter width.
RF_WRITE_FIRST, 1, 1 = register file bypasses WB writes internally; 0 = unit forwards WB to ID.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous reset, active low
i_rs_ID, i_rt_ID  in  NB_REG  ID source registers
i_uses_rt_ID  in  1  ID instruction reads rt
i_branch_ID  in  1  ID instruction is a branch comparing rs/rt
i_rs_EX, i_rt_EX  in  NB_REG  EX source registers
i_rd_EX  in  NB_REG  EX destination
i_write_reg_EX, i_mem_read_EX  in  1  EX writes register / is a load
i_mdu_start_EX  in  1  EX holds an MDU instruction
i_rd_MEM  in  NB_REG  MEM destination
i_write_reg_MEM, i_mem_read_MEM  in  1  MEM writes register / is a load
i_rd_WB  in  NB_REG  WB destination
i_write_reg_WB  in  1  WB writes register
i_clr_cnt  in  1  synchronous clear of stall counter
o_corto_rs, o_corto_rt  out  2  EX mux select: 00 none, 01 WB, 10 MEM
o_corto_br_rs, o_corto_br_rt  out  2  ID branch mux select: 00 regfile, 01 WB, 10 MEM
o_stall_pc, o_stall_ifid  out  1  hold PC / IF-ID register
o_flush_idex  out  1  insert bubble into ID-EX
o_stall_idex  out  1  hold ID-EX register
o_flush_exmem  out  1  insert bubble into EX-MEM
o_mdu_busy  out  1  MDU occupancy stall active
o_stall_cycles  out  NB_CNT  saturating count of cycles with o_stall_pc=1

Behaviour:
Definitions:
- MATCH(a, r) = (r != 0) && (r == a).
- srcID(r) = MATCH(i_rs_ID, r) || (i_uses_rt_ID && MATCH(i_rt_ID, r)).

EX forwarding (combinational):
- rs: MEM (10) if i_write_reg_MEM && MATCH(i_rs_EX, i_rd_MEM); else WB (01) if i_write_reg_WB && MATCH(i_rs_EX, i_rd_WB); else 00. Same rule for rt.
- Register 0 is never forwarded.

ID branch forwarding (combinational):
- 10 if i_branch_ID && i_write_reg_MEM && !i_mem_read_MEM && MATCH on rd_MEM.
- Else 01 if RF_WRITE_FIRST=0 && i_write_reg_WB && MATCH on rd_WB.
- Else 00.

Hazards (combinational; evaluated only when the MDU FSM does not stall):
- H1 load-use: i_mem_read_EX && i_write_reg_EX && srcID(i_rd_EX).
- H2 branch-EX: i_branch_ID && i_write_reg_EX && srcID(i_rd_EX).
- H3 branch-load-MEM: i_branch_ID && i_mem_read_MEM && i_write_reg_MEM && srcID(i_rd_MEM).
- Any of H1/H2/H3 gives o_stall_pc = o_stall_ifid = o_flush_idex = 1. A branch on a load in EX therefore stalls twice (H2 then H3).

MDU FSM, states RUN / BUSY / DONE, with counter cnt[NB_LAT]:
- RUN:
  - If i_mdu_start_EX && MDU_LAT > 1: stall this cycle. Next state is DONE if MDU_LAT == 2; otherwise BUSY with cnt <= MDU_LAT-3.
- BUSY:
  - Stall. If cnt == 0 go to DONE; else cnt <= cnt-1.
- DONE:
  - No MDU stall; i_mdu_start_EX is ignored (same instruction). Next state RUN.
- The MDU stall is asserted in the RUN start cycle and in BUSY. It sets o_mdu_busy = o_stall_pc = o_stall_ifid = o_stall_idex = o_flush_exmem = 1 and forces o_flush_idex = 0.
- Total MDU stall cycles = MDU_LAT-1. The instruction leaves EX on the DONE cycle.
- MDU stall masks H1-H3 (ID is frozen anyway). Forwarding selects remain live.

Performance counter:
- o_stall_cycles increments on each cycle with o_stall_pc = 1 and saturates at all-ones.
- i_clr_cnt has priority over the increment.

Reset (i_rst_n = 0 at the clock edge):
- State <= RUN, cnt <= 0, o_stall_cycles <= 0.
- While i_rst_n = 0, all stall/flush/busy outputs are forced to 0. Forwarding selects are forced to 00.
- Reset mid-BUSY aborts the sequence; the next cycle is RUN.

Decomposition:
- Package riesgos_pkg:
  - Forward-select constants: FWD_NONE = 00, FWD_WB = 01, FWD_MEM = 10.
  - MDU FSM state encoding.
  - REG_ZERO constant.
- Sub-module unidad_cortocircuito_sel: one combinational priority selector (src, rd_MEM, wr_MEM, rd_WB, wr_WB, en_WB) instantiated four times, for EX rs/rt and ID rs/rt.

Test Plan:
- WB writes r0 and EX reads rs=0 -> o_corto_rs=00. MEM and WB both write r5 with rs_EX=5 -> 10. Only WB writes r5 -> 01.
- Load r3 in EX, ID reads rt=3 with uses_rt=1 -> one cycle of stall_pc/ifid/flush_idex=1. With uses_rt=0 -> no stall.
- Branch on r4 with a load r4 in EX -> two consecutive stall cycles. The next cycle has o_corto_br_rs=00 (RF_WRITE_FIRST=1).
- MDU_LAT=4, mdu_start_EX pulse -> o_mdu_busy=1 for exactly 3 cycles, o_flush_idex=0 throughout, then one DONE cycle with no stall. Repeat with MDU_LAT=1 -> no stall.
- i_rst_n=0 during BUSY -> next cycle state RUN, outputs 0, o_stall_cycles=0.
- NB_CNT=2 with 5 stall cycles -> o_stall_cycles holds 3. i_clr_cnt during a stall -> 0.
